// File: rtl/r5p_pkg.sv
// Shared types for the r5p bus arbiter: requester ownership and read-return tags.
package r5p_pkg;

  // Which requester owns a grant, a lock or a pending read.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2
  } own_t;

  // Read-return tag: valid flag plus the owner that receives the data.
  typedef struct packed {
    logic vld;
    own_t own;
  } rtag_t;

  localparam rtag_t RTAG_IDLE = '{vld: 1'b0, own: OWN_NONE};

  // Build a tag for a transfer; only reads produce a valid tag.
  function automatic rtag_t rtag_make(input logic hs, input logic wen, input own_t own);
    rtag_t t;
    t = RTAG_IDLE;
    if (hs && !wen) begin
      t.vld = 1'b1;
      t.own = own;
    end else begin
      t = RTAG_IDLE;
    end
    return t;
  endfunction

endpackage

// File: rtl/r5p_bus_arbiter_chk.sv
// Protocol checks for the bus arbiter: a stalled (locked) requester must keep
// its request asserted until the handshake.
module r5p_bus_arbiter_chk
  import r5p_pkg::*;
(
  input logic clk,
  input logic rst,
  input own_t lock,
  input logic if_vld,
  input logic ls_vld
);

  a_if_hold: assert property (@(posedge clk) disable iff (rst) (lock == OWN_IF) |-> if_vld)
    else $error("IF dropped vld while its request was stalled");

  a_ls_hold: assert property (@(posedge clk) disable iff (rst) (lock == OWN_LS) |-> ls_vld)
    else $error("LS dropped vld while its request was stalled");

endmodule

// File: rtl/r5p_bus_arbiter_rtag.sv
// RLAT-deep shift register of read-return tags. A tag pushed in the handshake
// cycle pops exactly RLAT cycles later, aligned with the memory read data.
module r5p_bus_arbiter_rtag
  import r5p_pkg::*;
#(
  parameter int unsigned RLAT = 1
) (
  input  logic  clk,
  input  logic  rst,
  input  rtag_t push,
  output rtag_t pop
);

  generate
    if (RLAT == 0) begin : g_comb
      assign pop = push;
    end else begin : g_pipe
      rtag_t tag_r [RLAT];

      // Shift tags one stage per cycle; reset discards everything in flight.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < int'(RLAT); i++) begin
            tag_r[i] <= RTAG_IDLE;
          end
        end else begin
          tag_r[0] <= push;
          for (int i = 1; i < int'(RLAT); i++) begin
            tag_r[i] <= tag_r[i-1];
          end
        end
      end

      assign pop = tag_r[RLAT-1];
    end
  endgenerate

endmodule

// File: rtl/r5p_bus_arbiter.sv
// Shares one memory port between the r5p instruction-fetch and load/store
// buses. LS has priority unless IF has been refused MAXW times in a row; a
// stalled request keeps its grant; read data is routed back by tag.
module r5p_bus_arbiter
  import r5p_pkg::*;
#(
  parameter int unsigned AW   = 32,
  parameter int unsigned DW   = 32,
  parameter int unsigned BW   = DW/8,
  parameter int unsigned RLAT = 1,
  parameter int unsigned MAXW = 4
) (
  input  logic          clk,
  input  logic          rst,
  // instruction fetch
  input  logic          if_vld,
  input  logic [AW-1:0] if_adr,
  output logic [DW-1:0] if_rdt,
  output logic          if_rdy,
  // load/store
  input  logic          ls_vld,
  input  logic          ls_wen,
  input  logic [AW-1:0] ls_adr,
  input  logic [BW-1:0] ls_ben,
  input  logic [DW-1:0] ls_wdt,
  output logic [DW-1:0] ls_rdt,
  output logic          ls_rdy,
  // memory
  output logic          mem_vld,
  output logic          mem_wen,
  output logic [AW-1:0] mem_adr,
  output logic [BW-1:0] mem_ben,
  output logic [DW-1:0] mem_wdt,
  input  logic [DW-1:0] mem_rdt,
  input  logic          mem_rdy
);

  localparam logic [3:0] MAXW_C = 4'(MAXW);

  own_t          lock_r;
  own_t          grant_s;
  logic [3:0]    starve_r;
  logic          hs_s;
  rtag_t         push_s;
  rtag_t         pop_s;
  logic [DW-1:0] if_rdt_r;
  logic [DW-1:0] ls_rdt_r;

  // Pick the owner of the memory port this cycle (nothing while in reset).
  always_comb begin
    grant_s = OWN_NONE;
    if (rst) begin
      grant_s = OWN_NONE;
    end else if (lock_r != OWN_NONE) begin
      grant_s = lock_r;
    end else if (ls_vld && !((starve_r == MAXW_C) && if_vld)) begin
      grant_s = OWN_LS;
    end else if (if_vld) begin
      grant_s = OWN_IF;
    end else begin
      grant_s = OWN_NONE;
    end
  end

  // Route the granted requester onto the memory port and return its handshake.
  always_comb begin
    mem_vld = 1'b0;
    mem_wen = 1'b0;
    mem_adr = '0;
    mem_ben = '0;
    mem_wdt = '0;
    if_rdy  = 1'b0;
    ls_rdy  = 1'b0;
    case (grant_s)
      OWN_IF: begin
        mem_vld = if_vld;
        mem_wen = 1'b0;
        mem_adr = if_adr;
        mem_ben = '1;
        mem_wdt = '0;
        if_rdy  = mem_rdy;
      end
      OWN_LS: begin
        mem_vld = ls_vld;
        mem_wen = ls_wen;
        mem_adr = ls_adr;
        mem_ben = ls_ben;
        mem_wdt = ls_wdt;
        ls_rdy  = mem_rdy;
      end
      default: begin
        mem_vld = 1'b0;
        if_rdy  = 1'b0;
        ls_rdy  = 1'b0;
      end
    endcase
  end

  assign hs_s   = mem_vld & mem_rdy;
  assign push_s = rtag_make(hs_s, mem_wen, grant_s);

  // Hold the grant on a stalled request and count consecutive IF refusals.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_r   <= OWN_NONE;
      starve_r <= 4'd0;
    end else begin
      if ((grant_s != OWN_NONE) && mem_vld && !mem_rdy) begin
        lock_r <= grant_s;
      end else begin
        lock_r <= OWN_NONE;
      end
      if (if_vld && if_rdy) begin
        starve_r <= 4'd0;
      end else if (if_vld && (starve_r != MAXW_C)) begin
        starve_r <= starve_r + 4'd1;
      end else begin
        starve_r <= starve_r;
      end
    end
  end

  r5p_bus_arbiter_rtag #(
    .RLAT (RLAT)
  ) u_rtag (
    .clk  (clk),
    .rst  (rst),
    .push (push_s),
    .pop  (pop_s)
  );

  // Capture returning read data into the owner's hold register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_rdt_r <= '0;
      ls_rdt_r <= '0;
    end else begin
      if (pop_s.vld && (pop_s.own == OWN_IF)) begin
        if_rdt_r <= mem_rdt;
      end
      if (pop_s.vld && (pop_s.own == OWN_LS)) begin
        ls_rdt_r <= mem_rdt;
      end
    end
  end

  // With zero latency the data is forwarded in the handshake cycle itself.
  generate
    if (RLAT == 0) begin : g_fwd
      assign if_rdt = (pop_s.vld && (pop_s.own == OWN_IF)) ? mem_rdt : if_rdt_r;
      assign ls_rdt = (pop_s.vld && (pop_s.own == OWN_LS)) ? mem_rdt : ls_rdt_r;
    end else begin : g_hold
      assign if_rdt = if_rdt_r;
      assign ls_rdt = ls_rdt_r;
    end
  endgenerate

  r5p_bus_arbiter_chk u_chk (
    .clk    (clk),
    .rst    (rst),
    .lock   (lock_r),
    .if_vld (if_vld),
    .ls_vld (ls_vld)
  );

endmodule

// File: tb/tb_r5p_bus_arbiter.sv
// Directed bench for r5p_bus_arbiter: one instance with RLAT=1 and one with
// RLAT=2 share all inputs; each check targets the instance it is meant for.
module tb_r5p_bus_arbiter;

  logic        clk;
  logic        rst;
  logic        if_vld;
  logic [31:0] if_adr;
  logic        ls_vld;
  logic        ls_wen;
  logic [31:0] ls_adr;
  logic [3:0]  ls_ben;
  logic [31:0] ls_wdt;
  logic [31:0] mem_rdt;
  logic        mem_rdy;

  logic [31:0] if_rdt_1, ls_rdt_1, mem_adr_1, mem_wdt_1;
  logic        if_rdy_1, ls_rdy_1, mem_vld_1, mem_wen_1;
  logic [3:0]  mem_ben_1;
  logic [31:0] if_rdt_2, ls_rdt_2, mem_adr_2, mem_wdt_2;
  logic        if_rdy_2, ls_rdy_2, mem_vld_2, mem_wen_2;
  logic [3:0]  mem_ben_2;

  int n_checks;
  int n_errors;

  r5p_bus_arbiter #(.AW(32), .DW(32), .BW(4), .RLAT(1), .MAXW(4)) dut1 (
    .clk(clk), .rst(rst),
    .if_vld(if_vld), .if_adr(if_adr), .if_rdt(if_rdt_1), .if_rdy(if_rdy_1),
    .ls_vld(ls_vld), .ls_wen(ls_wen), .ls_adr(ls_adr), .ls_ben(ls_ben),
    .ls_wdt(ls_wdt), .ls_rdt(ls_rdt_1), .ls_rdy(ls_rdy_1),
    .mem_vld(mem_vld_1), .mem_wen(mem_wen_1), .mem_adr(mem_adr_1),
    .mem_ben(mem_ben_1), .mem_wdt(mem_wdt_1), .mem_rdt(mem_rdt), .mem_rdy(mem_rdy)
  );

  r5p_bus_arbiter #(.AW(32), .DW(32), .BW(4), .RLAT(2), .MAXW(4)) dut2 (
    .clk(clk), .rst(rst),
    .if_vld(if_vld), .if_adr(if_adr), .if_rdt(if_rdt_2), .if_rdy(if_rdy_2),
    .ls_vld(ls_vld), .ls_wen(ls_wen), .ls_adr(ls_adr), .ls_ben(ls_ben),
    .ls_wdt(ls_wdt), .ls_rdt(ls_rdt_2), .ls_rdy(ls_rdy_2),
    .mem_vld(mem_vld_2), .mem_wen(mem_wen_2), .mem_adr(mem_adr_2),
    .mem_ben(mem_ben_2), .mem_wdt(mem_wdt_2), .mem_rdt(mem_rdt), .mem_rdy(mem_rdy)
  );

  // 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge so new inputs can be driven.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_vld  = 1'b0;
    if_adr  = 32'h0;
    ls_vld  = 1'b0;
    ls_wen  = 1'b0;
    ls_adr  = 32'h0;
    ls_ben  = 4'h0;
    ls_wdt  = 32'h0;
    mem_rdt = 32'h0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    mem_rdy  = 1'b0;
    idle_inputs();

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_if_rdt", if_rdt_1, 32'h0);
    check("rst_ls_rdt", ls_rdt_1, 32'h0);
    check("rst_if_rdy", {31'h0, if_rdy_1}, 32'h0);
    check("rst_ls_rdy", {31'h0, ls_rdy_1}, 32'h0);
    check("rst_mem_vld", {31'h0, mem_vld_1}, 32'h0);
    next_cycle();
    rst = 1'b0;

    // Single IF read, RLAT=1
    if_vld = 1'b1; if_adr = 32'h100; mem_rdy = 1'b1;
    @(negedge clk);
    check("t1_mem_adr", mem_adr_1, 32'h100);
    check("t1_if_rdy", {31'h0, if_rdy_1}, 32'h1);
    check("t1_mem_vld", {31'h0, mem_vld_1}, 32'h1);
    check("t1_mem_wen", {31'h0, mem_wen_1}, 32'h0);
    check("t1_mem_ben", {28'h0, mem_ben_1}, 32'hF);
    next_cycle();
    if_vld = 1'b0; mem_rdt = 32'hDEADBEEF;
    @(negedge clk);
    check("t1_if_rdt_early", if_rdt_1, 32'h0);
    next_cycle();
    mem_rdt = 32'h0;
    @(negedge clk);
    check("t1_if_rdt", if_rdt_1, 32'hDEADBEEF);
    next_cycle();
    @(negedge clk);
    check("t1_if_rdt_hold", if_rdt_1, 32'hDEADBEEF);
    next_cycle();

    // Simultaneous IF read and LS write: LS first, IF next
    if_vld = 1'b1; if_adr = 32'h300;
    ls_vld = 1'b1; ls_wen = 1'b1; ls_adr = 32'h200; ls_ben = 4'b0011; ls_wdt = 32'h55;
    @(negedge clk);
    check("t2_mem_wen", {31'h0, mem_wen_1}, 32'h1);
    check("t2_mem_adr", mem_adr_1, 32'h200);
    check("t2_mem_ben", {28'h0, mem_ben_1}, 32'h3);
    check("t2_mem_wdt", mem_wdt_1, 32'h55);
    check("t2_ls_rdy", {31'h0, ls_rdy_1}, 32'h1);
    check("t2_if_rdy", {31'h0, if_rdy_1}, 32'h0);
    next_cycle();
    ls_vld = 1'b0; ls_wen = 1'b0;
    @(negedge clk);
    check("t2_if_adr", mem_adr_1, 32'h300);
    check("t2_if_rdy2", {31'h0, if_rdy_1}, 32'h1);
    check("t2_if_wen", {31'h0, mem_wen_1}, 32'h0);
    next_cycle();

    // IF stalled three cycles; LS arriving meanwhile must wait
    if_vld = 1'b1; if_adr = 32'h400; mem_rdy = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c == 1) begin
        ls_vld = 1'b1; ls_wen = 1'b0; ls_adr = 32'h500; ls_ben = 4'hF;
      end
      if (c == 3) mem_rdy = 1'b1;
      @(negedge clk);
      check($sformatf("t3_mem_adr_c%0d", c), mem_adr_1, 32'h400);
      check($sformatf("t3_ls_rdy_c%0d", c), {31'h0, ls_rdy_1}, 32'h0);
      check($sformatf("t3_if_rdy_c%0d", c), {31'h0, if_rdy_1}, (c == 3) ? 32'h1 : 32'h0);
      next_cycle();
    end
    if_vld = 1'b0;
    @(negedge clk);
    check("t3_ls_adr", mem_adr_1, 32'h500);
    check("t3_ls_rdy", {31'h0, ls_rdy_1}, 32'h1);
    next_cycle();
    idle_inputs();

    // Anti-starvation: LS writes every cycle, IF wins every fifth cycle
    if_vld = 1'b1; if_adr = 32'h700;
    ls_vld = 1'b1; ls_wen = 1'b1; ls_adr = 32'h600; ls_ben = 4'hF;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      check($sformatf("t4_if_rdy_c%0d", c), {31'h0, if_rdy_1}, (c % 5 == 0) ? 32'h1 : 32'h0);
      check($sformatf("t4_ls_rdy_c%0d", c), {31'h0, ls_rdy_1}, (c % 5 == 0) ? 32'h0 : 32'h1);
      check($sformatf("t4_mem_adr_c%0d", c), mem_adr_1, (c % 5 == 0) ? 32'h700 : 32'h600);
      next_cycle();
    end
    idle_inputs();
    next_cycle();

    // Alternating reads with RLAT=2
    if_vld = 1'b1; if_adr = 32'h0;
    @(negedge clk);
    check("t5_h0_adr", mem_adr_2, 32'h0);
    check("t5_h0_if_rdy", {31'h0, if_rdy_2}, 32'h1);
    next_cycle();
    if_vld = 1'b0; ls_vld = 1'b1; ls_wen = 1'b0; ls_adr = 32'h4; ls_ben = 4'hF;
    @(negedge clk);
    check("t5_h1_adr", mem_adr_2, 32'h4);
    check("t5_h1_ls_rdy", {31'h0, ls_rdy_2}, 32'h1);
    next_cycle();
    ls_vld = 1'b0; if_vld = 1'b1; if_adr = 32'h8; mem_rdt = 32'h1000;
    @(negedge clk);
    check("t5_h2_adr", mem_adr_2, 32'h8);
    check("t5_h2_if_rdt", if_rdt_2, 32'h0);
    next_cycle();
    if_vld = 1'b0; mem_rdt = 32'h1004;
    @(negedge clk);
    check("t5_h3_if_rdt", if_rdt_2, 32'h1000);
    check("t5_h3_ls_rdt", ls_rdt_2, 32'h0);
    next_cycle();
    mem_rdt = 32'h1008;
    @(negedge clk);
    check("t5_h4_if_rdt", if_rdt_2, 32'h1000);
    check("t5_h4_ls_rdt", ls_rdt_2, 32'h1004);
    next_cycle();
    mem_rdt = 32'h0;
    @(negedge clk);
    check("t5_h5_if_rdt", if_rdt_2, 32'h1008);
    check("t5_h5_ls_rdt", ls_rdt_2, 32'h1004);
    next_cycle();

    // Reset with two reads in flight
    if_vld = 1'b1; if_adr = 32'h10;
    next_cycle();
    if_vld = 1'b0; ls_vld = 1'b1; ls_wen = 1'b0; ls_adr = 32'h14;
    next_cycle();
    if_vld = 1'b1; mem_rdt = 32'hAAAA5555; rst = 1'b1;
    #1;
    check("t6_if_rdt_2", if_rdt_2, 32'h0);
    check("t6_ls_rdt_2", ls_rdt_2, 32'h0);
    check("t6_if_rdt_1", if_rdt_1, 32'h0);
    check("t6_ls_rdt_1", ls_rdt_1, 32'h0);
    check("t6_mem_vld", {31'h0, mem_vld_2}, 32'h0);
    check("t6_if_rdy", {31'h0, if_rdy_2}, 32'h0);
    check("t6_ls_rdy", {31'h0, ls_rdy_2}, 32'h0);
    check("t6_mem_adr", mem_adr_2, 32'h0);
    next_cycle();
    rst = 1'b0; if_vld = 1'b0; ls_vld = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("t6_post_if_rdt_c%0d", c), if_rdt_2, 32'h0);
      check($sformatf("t6_post_ls_rdt_c%0d", c), ls_rdt_2, 32'h0);
      check($sformatf("t6_post_if_rdt1_c%0d", c), if_rdt_1, 32'h0);
      next_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/r5p_bus_arbiter.md
Name: r5p_bus_arbiter

Overview:
- Shares one memory port between the core's instruction-fetch (IF) bus and load/store (LS) bus, so an r5p core can run on a single-ported unified memory.
- Sits between r5p_core and the memory/interconnect.
- Per-cycle arbitration; a stalled request holds its grant until it completes; an anti-starvation counter protects IF.
- Read data is returned to the owning requester after a fixed memory read latency and held there until that requester's next read returns.

Parameters:
- AW, 32, address width (IF and LS addresses are both AW).
- DW, 32, data width (IF and LS data are both DW).
- BW, DW/8, byte-enable width.
- RLAT, 1, memory read latency in cycles after the vld&rdy handshake; legal range 0..4.
- MAXW, 4, number of consecutive cycles IF may be refused before it takes priority; legal range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- if_vld  in  1  IF request
- if_adr  in  AW  IF address
- if_rdt  out  DW  IF read data
- if_rdy  out  1  IF handshake
- ls_vld  in  1  LS request
- ls_wen  in  1  LS write enable
- ls_adr  in  AW  LS address
- ls_ben  in  BW  LS byte enable
- ls_wdt  in  DW  LS write data
- ls_rdt  out  DW  LS read data
- ls_rdy  out  1  LS handshake
- mem_vld  out  1  memory request
- mem_wen  out  1  memory write enable
- mem_adr  out  AW  memory address
- mem_ben  out  BW  memory byte enable
- mem_wdt  out  DW  memory write data
- mem_rdt  in  DW  memory read data
- mem_rdy  in  1  memory handshake

Behaviour:
- Reset (async, rst=1):
  - lock=NONE, starve counter=0, tag pipeline cleared.
  - if_rdt=0, ls_rdt=0.
  - if_rdy=0, ls_rdy=0, mem_vld=0.
- Arbitration state: lock in {NONE, IF, LS}.
- Grant selection:
  - If lock!=NONE, grant=lock, irrespective of the other request.
  - If lock=NONE: LS wins when ls_vld, unless starve==MAXW and if_vld, in which case IF wins.
  - Otherwise IF wins when if_vld. With no request, grant=NONE.
- Mux:
  - mem_vld = granted requester's vld.
  - mem_adr, mem_ben, mem_wen, mem_wdt are taken from the granted requester.
  - IF side forces wen=0 and ben=all-ones; the non-LS fields are don't-care on writes.
- Handshake:
  - Granted requester's rdy = mem_rdy. The non-granted requester's rdy = 0.
  - Combinational path vld -> mem_vld -> mem_rdy -> rdy is permitted; there are no combinational loops inside this block.
- Lock transitions:
  - If the granted requester has vld & ~mem_rdy, lock <= that requester; it is a stalled request and must not be preempted.
  - On a handshake, lock <= NONE.
  - A requester that drops vld while locked is a protocol violation; assert in simulation.
- Starve counter:
  - Increments (saturating at MAXW) in each cycle where if_vld & ~if_rdy.
  - Clears on an IF handshake.
  - Does not change when if_vld=0.
- Read return:
  - Each read handshake (mem_wen=0) pushes tag {valid, owner} into an RLAT-deep shift register.
  - When a tag emerges, mem_rdt is captured into the owner's rdt register.
  - RLAT=0: rdt is driven combinationally from mem_rdt in the handshake cycle and registered for hold.
  - Writes push an invalid tag.
  - Back-to-back reads from alternating owners each capture correctly; the pipeline accepts one transfer per cycle.
- Held data: if_rdt/ls_rdt keep their last captured value indefinitely. The core relies on this during stalls.
- Reset mid-operation: pending tags are discarded; data returning after reset is ignored.
- Simultaneous first requests: LS wins (matching the core's load-stall fetch suppression); IF stays refused until LS completes or starvation triggers.

Decomposition:
- r5p_pkg: add an owner enum (OWN_NONE, OWN_IF, OWN_LS) and a tag struct {vld, own}.
- One sub-module, r5p_bus_arbiter_rtag: the RLAT-deep tag shift register with push/pop outputs. It is reusable for a future multi-master interconnect.

Test Plan:
- Only if_vld=1, adr=0x100, mem_rdy=1, RLAT=1, mem_rdt=0xDEADBEEF one cycle later -> mem_adr=0x100, if_rdy=1, if_rdt=0xDEADBEEF from the following cycle, and held while if_vld=0.
- if_vld=1 and ls_vld=1 (write, adr=0x200, ben=4'b0011) in the same cycle -> mem_wen=1, mem_adr=0x200, ls_rdy=1, if_rdy=0; IF is granted the next cycle.
- IF granted, mem_rdy=0 for 3 cycles, ls_vld rises in cycle 1 -> grant stays IF (mem_adr constant) until the handshake; ls_rdy=0 throughout.
- ls_vld held high for 10 cycles with MAXW=4, if_vld=1 -> IF gets if_rdy=1 in cycle 5; starve resets to 0; LS resumes.
- Alternating reads IF adr 0x0, LS adr 0x4, IF adr 0x8 with RLAT=2, mem_rdt=adr+0x1000 -> if_rdt=0x1000 then 0x1008, ls_rdt=0x1004, each landing exactly 2 cycles after its handshake.
- rst asserted with 2 reads in flight -> all outputs are zero immediately; post-reset mem_rdt values do not update if_rdt/ls_rdt.
